// File: rtl/abc_sweeper.sv
// Exhaustive 3-input stimulus sweeper: drives {A,B,C}=0..7 for HOLD cycles each and captures F/G per vector.
// Latency: done rises 8*HOLD edges after the start edge; A/B/C/index/tables are registered outputs.
// No backpressure: start is honoured only in IDLE/DONE, abort only in DRIVE (abort pre-empts a same-edge capture).
module abc_sweeper #(
    parameter int HOLD = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       F,
    input  logic       G,
    output logic [2:0] index,
    output logic [7:0] f_table,
    output logic [7:0] g_table,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [7:0] hold_q,  hold_d;
    logic [7:0] f_q,     f_d;
    logic [7:0] g_q,     g_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            index_q <= 3'd0;
            hold_q  <= 8'd0;
            f_q     <= 8'd0;
            g_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            hold_q  <= hold_d;
            f_q     <= f_d;
            g_q     <= g_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        hold_d  = hold_q;
        f_d     = f_q;
        g_d     = g_q;
        case (state_q)
            IDLE, DONE: begin
                // a simultaneous abort is meaningless outside DRIVE, so start wins
                if (start) begin
                    state_d = DRIVE;
                    index_d = 3'd0;
                    hold_d  = 8'd0;
                    f_d     = 8'd0;
                    g_d     = 8'd0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    index_d = 3'd0;
                    hold_d  = 8'd0;
                end else if (hold_q == HOLD_LAST) begin
                    f_d[index_q] = F;
                    g_d[index_q] = G;
                    hold_d       = 8'd0;
                    if (index_q == 3'd7) begin
                        state_d = DONE;
                        index_d = 3'd0;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = 3'd0;
                hold_d  = 8'd0;
            end
        endcase
    end

    assign {A, B, C} = index_q;
    assign index     = index_q;
    assign f_table   = f_q;
    assign g_table   = g_q;
    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_abc_sweeper.sv
// Randomized bench for abc_sweeper: downstream unit is a truth-table lookup, expected outputs come from a
// cycle-count model of the sweep (vector = k/HOLD, captured vectors = bits below that count).
module tb_abc_sweeper;

    logic       clk;
    logic       resetn;
    logic       start5, abort5, start1, abort1;
    logic       a5, b5, c5, f5, g5, busy5, done5;
    logic       a1, b1, c1, f1, g1, busy1, done1;
    logic [2:0] index5, index1;
    logic [7:0] ft5, gt5, ft1, gt1;
    logic [7:0] f_tt, g_tt;

    int checks;
    int errors;

    abc_sweeper #(.HOLD(5)) dut5 (
        .clk(clk), .resetn(resetn), .start(start5), .abort(abort5),
        .A(a5), .B(b5), .C(c5), .F(f5), .G(g5),
        .index(index5), .f_table(ft5), .g_table(gt5), .busy(busy5), .done(done5)
    );

    abc_sweeper #(.HOLD(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .abort(abort1),
        .A(a1), .B(b1), .C(c1), .F(f1), .G(g1),
        .index(index1), .f_table(ft1), .g_table(gt1), .busy(busy1), .done(done1)
    );

    // downstream combinational unit modelled as an arbitrary 3-input truth table
    assign f5 = f_tt[{a5, b5, c5}];
    assign g5 = g_tt[{a5, b5, c5}];
    assign f1 = f_tt[{a1, b1, c1}];
    assign g1 = g_tt[{a1, b1, c1}];

    wire [23:0] obs5 = {busy5, done5, a5, b5, c5, index5, ft5, gt5};
    wire [23:0] obs1 = {busy1, done1, a1, b1, c1, index1, ft1, gt1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] low_mask(int n);
        logic [7:0] m;
        m = 8'd0;
        for (int i = 0; i < 8; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    // state seen k edges after the start edge of an uninterrupted sweep
    function automatic logic [23:0] sweep_model(int k, int h, logic [7:0] ftt, logic [7:0] gtt);
        logic [2:0] idx;
        logic [7:0] m;
        if (k < 8 * h) begin
            idx = 3'(k / h);
            m   = low_mask(k / h);
            return {1'b1, 1'b0, idx, idx, ftt & m, gtt & m};
        end
        m = low_mask(8);
        return {1'b0, 1'b1, 3'd0, 3'd0, ftt & m, gtt & m};
    endfunction

    function automatic logic [23:0] idle_model(int captured, logic [7:0] ftt, logic [7:0] gtt);
        logic [7:0] m;
        m = low_mask(captured);
        return {1'b0, 1'b0, 3'd0, 3'd0, ftt & m, gtt & m};
    endfunction

    task automatic test_reset();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (obs5 !== 24'd0) begin
            errors++;
            $display("FAIL reset_async_h5 got %h exp %h", obs5, 24'd0);
        end
        checks++;
        if (obs1 !== 24'd0) begin
            errors++;
            $display("FAIL reset_async_h1 got %h exp %h", obs1, 24'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs5 !== 24'd0) begin
                errors++;
                $display("FAIL reset_release_idle k=%0d got %h exp %h", k, obs5, 24'd0);
            end
        end
    endtask

    task automatic test_full_sweep(input logic [7:0] ftt, input logic [7:0] gtt);
        logic [23:0] exp;
        f_tt = ftt;
        g_tt = gtt;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            exp = sweep_model(k, 5, ftt, gtt);
            checks++;
            if (obs5 !== exp) begin
                errors++;
                $display("FAIL sweep_h5 tt=%h/%h k=%0d got %h exp %h", ftt, gtt, k, obs5, exp);
            end
        end
        // tables hold in DONE, and abort there is ignored
        abort5 = 1'b1;
        for (int k = 41; k <= 43; k++) begin
            @(negedge clk);
            exp = sweep_model(k, 5, ftt, gtt);
            checks++;
            if (obs5 !== exp) begin
                errors++;
                $display("FAIL done_hold k=%0d got %h exp %h", k, obs5, exp);
            end
        end
        abort5 = 1'b0;
    endtask

    task automatic test_hold1(input logic [7:0] ftt, input logic [7:0] gtt);
        logic [23:0] exp;
        f_tt = ftt;
        g_tt = gtt;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            exp = sweep_model(k, 1, ftt, gtt);
            checks++;
            if (obs1 !== exp) begin
                errors++;
                $display("FAIL sweep_h1 tt=%h/%h k=%0d got %h exp %h", ftt, gtt, k, obs1, exp);
            end
        end
    endtask

    task automatic test_abort(input int ka, input logic [7:0] ftt, input logic [7:0] gtt);
        logic [23:0] exp;
        f_tt = ftt;
        g_tt = gtt;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        for (int k = 1; k < ka; k++) begin
            @(negedge clk);
            exp = sweep_model(k, 5, ftt, gtt);
            checks++;
            if (obs5 !== exp) begin
                errors++;
                $display("FAIL abort_pre ka=%0d k=%0d got %h exp %h", ka, k, obs5, exp);
            end
        end
        abort5 = 1'b1;
        // capture due on the abort edge is dropped: only vectors finished by edge ka-1 survive
        exp = idle_model((ka - 1) / 5, ftt, gtt);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++;
            if (obs5 !== exp) begin
                errors++;
                $display("FAIL abort_idle ka=%0d j=%0d got %h exp %h", ka, j, obs5, exp);
            end
        end
        abort5 = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [23:0] exp;
        f_tt = 8'h96;
        g_tt = 8'hE8;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            start5 = (k == 21);
            @(negedge clk);
            exp = sweep_model(k, 5, 8'h96, 8'hE8);
            checks++;
            if (obs5 !== exp) begin
                errors++;
                $display("FAIL start_in_drive k=%0d got %h exp %h", k, obs5, exp);
            end
        end
        // restart from DONE with abort also high: start wins, tables clear
        f_tt = 8'h3C;
        g_tt = 8'hA5;
        start5 = 1'b1;
        abort5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        abort5 = 1'b0;
        for (int k = 0; k <= 40; k += 4) begin
            if (k > 0) repeat (4) @(negedge clk);
            exp = sweep_model(k, 5, 8'h3C, 8'hA5);
            checks++;
            if (obs5 !== exp) begin
                errors++;
                $display("FAIL restart_from_done k=%0d got %h exp %h", k, obs5, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] exp;
        f_tt = 8'h96;
        g_tt = 8'hE8;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        repeat (25) @(negedge clk);
        exp = sweep_model(25, 5, 8'h96, 8'hE8);
        checks++;
        if (obs5 !== exp) begin
            errors++;
            $display("FAIL reset_mid_pre got %h exp %h", obs5, exp);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (obs5 !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_async got %h exp %h", obs5, 24'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs5 !== 24'd0) begin
                errors++;
                $display("FAIL reset_mid_idle k=%0d got %h exp %h", k, obs5, 24'd0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b1;
        start5 = 1'b0;
        abort5 = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        f_tt   = 8'h96;
        g_tt   = 8'hE8;

        test_reset();
        test_full_sweep(8'h96, 8'hE8);
        test_full_sweep(8'($urandom), 8'($urandom));
        test_hold1(8'h96, 8'hE8);
        test_hold1(8'($urandom), 8'($urandom));
        test_abort(16, 8'h96, 8'hE8);
        test_abort(20, 8'h96, 8'hE8);
        for (int i = 0; i < 4; i++)
            test_abort(int'($urandom_range(1, 39)), 8'($urandom), 8'($urandom));
        test_start_ignored();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
